// File: rtl/fifomem_arb_ctrl.sv
// Round-robin write arbiter and synchronous FIFO sequencer wrapped around one
// fifomem instance: owns both pointers, occupancy flags and the sticky underflow flag.
module fifomem_arb_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [DATASIZE-1:0]      mem_wdata,
  output logic [ADDRSIZE-1:0]      mem_waddr,
  output logic                     mem_wclken,
  output logic                     mem_wfull,
  output logic [ADDRSIZE-1:0]      mem_raddr,
  input  logic [DATASIZE-1:0]      mem_rdata,
  input  logic                     rd_en,
  output logic [DATASIZE-1:0]      rdata,
  output logic                     rempty,
  output logic [ADDRSIZE:0]        count,
  output logic                     err_underflow
);
  localparam int IDW   = $clog2(NREQ);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [ADDRSIZE:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IDW-1:0]    rr_q, rr_d, gid_q, gid_d;
  logic              uflow_q, uflow_d;

  logic [NREQ-1:0][DATASIZE-1:0] req_arr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] g;
  logic           found, push, pop;

  assign req_arr = req_data;

  // Extra MSB on the pointers separates full (diff = DEPTH) from empty (diff = 0).
  assign count     = wptr_q - rptr_q;
  assign mem_wfull = (count == (ADDRSIZE+1)'(DEPTH));
  assign rempty    = (count == '0);

  // Search order starts at rr_q and wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        g     = sum[IDW-1:0];
      end
    end
  end

  assign push       = found & ~mem_wfull;
  assign pop        = rd_en & ~rempty;
  assign req_ready  = push ? (NREQ'(1) << g) : '0;
  assign mem_wclken = push;
  assign mem_wdata  = req_arr[g];
  assign mem_waddr  = wptr_q[ADDRSIZE-1:0];
  assign mem_raddr  = rptr_q[ADDRSIZE-1:0];
  assign rdata      = mem_rdata;
  assign grant_id   = gid_q;
  assign err_underflow = uflow_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    uflow_d = uflow_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
      rr_d   = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
      gid_d  = g;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    // No bypass: a pop against a registered-empty FIFO is an error even if a push lands.
    if (rd_en && rempty) uflow_d = 1'b1;
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      uflow_q <= uflow_d;
    end
  end
endmodule

// File: tb/tb_fifomem_arb_ctrl.sv
// Scoreboard bench for fifomem_arb_ctrl: directed scenarios, then randomized traffic
// checked against a queue-based model; a behavioural fifomem hangs off the memory port.
module tb_fifomem_arb_ctrl;
  localparam int DS = 8, AS = 4, NR = 4, DEPTH = 16;

  logic              wclk, wrst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*DS-1:0]  req_data;
  logic [1:0]        grant_id;
  logic [DS-1:0]     mem_wdata, mem_rdata, rdata;
  logic [AS-1:0]     mem_waddr, mem_raddr;
  logic              mem_wclken, mem_wfull, rd_en, rempty, err_underflow;
  logic [AS:0]       count;

  fifomem_arb_ctrl #(.DATASIZE(DS), .ADDRSIZE(AS), .NREQ(NR)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .mem_wdata(mem_wdata),
    .mem_waddr(mem_waddr), .mem_wclken(mem_wclken), .mem_wfull(mem_wfull),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .rd_en(rd_en), .rdata(rdata),
    .rempty(rempty), .count(count), .err_underflow(err_underflow));

  // Behavioural fifomem: clocked write, asynchronous read.
  logic [DS-1:0] mem [DEPTH];
  always @(posedge wclk) if (mem_wclken) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks = 0, errors = 0;
  logic [DS-1:0] sb[$];
  logic [DS-1:0] dat [NR];
  int  cnt_m = 0, rr_m = 0, gid_m = 0;
  bit  err_m = 0;
  logic [NR-1:0] acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: check registered state, drive inputs, check grant, advance the model.
  task automatic cycle(input logic [NR-1:0] v, input logic rd, input logic rst = 1'b0);
    int g;
    logic [NR-1:0] exp_rdy;
    @(negedge wclk);
    chk("count", 32'(count), 32'(cnt_m));
    chk("rempty", 32'(rempty), 32'(cnt_m == 0));
    chk("wfull", 32'(mem_wfull), 32'(cnt_m == DEPTH));
    chk("underflow", 32'(err_underflow), 32'(err_m));
    chk("grant_id", 32'(grant_id), 32'(gid_m));
    req_valid = v;
    for (int i = 0; i < NR; i++) req_data[i*DS +: DS] = dat[i];
    rd_en = rd;
    wrst  = rst;
    #1;
    g = -1;
    if (cnt_m < DEPTH)
      for (int k = 0; k < NR; k++)
        if (g < 0 && v[(rr_m + k) % NR]) g = (rr_m + k) % NR;
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("wclken", 32'(mem_wclken), 32'(g >= 0));
    acc = '0;
    if (rst) begin
      cnt_m = 0; rr_m = 0; gid_m = 0; err_m = 0;
      sb.delete();
    end else begin
      if (rd && cnt_m == 0) err_m = 1;
      else if (rd) cnt_m--;
      if (g >= 0) begin
        sb.push_back(dat[g]);
        cnt_m++;
        rr_m  = (g + 1) % NR;
        gid_m = g;
        acc   = exp_rdy;
      end
    end
  endtask

  // Monitor: whenever the DUT offers a word that is being popped, it must be the oldest expected.
  initial forever begin
    @(negedge wclk);
    #2;
    if (wrst === 1'b0 && rd_en === 1'b1 && rempty === 1'b0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected actual=%0h expected=none at %0t", rdata, $time);
      end else begin
        chk("rdata", 32'(rdata), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [NR-1:0] pend;
    int rdp;
    wrst = 1'b1; req_valid = '0; req_data = '0; rd_en = 1'b0;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    repeat (2) @(posedge wclk);

    // Single requester, three pushes then three pops.
    dat[0] = 8'h11; cycle(4'b0001, 0);
    dat[0] = 8'h22; cycle(4'b0001, 0);
    dat[0] = 8'h33; cycle(4'b0001, 0);
    repeat (3) cycle(4'b0000, 1);
    cycle(4'b0000, 0);

    // All four requesters holding valid: strict rotation.
    for (int i = 0; i < NR; i++) dat[i] = 8'hA0 + 8'(i);
    repeat (8) cycle(4'b1111, 0);

    // Fill to full, stall, then pop frees exactly one slot.
    while (cnt_m < DEPTH) begin dat[0] = 8'(cnt_m + 8'h40); cycle(4'b0001, 0); end
    dat[2] = 8'h77;
    repeat (2) cycle(4'b0100, 0);
    cycle(4'b0100, 1);
    cycle(4'b0100, 0);
    // Continuous push and pop against full.
    for (int i = 0; i < 6; i++) begin dat[1] = 8'(8'hC0 + i); cycle(4'b0010, 1); end

    // Drain, then underflow is sticky until reset.
    while (cnt_m > 0) cycle(4'b0000, 1);
    cycle(4'b0000, 1);
    repeat (3) cycle(4'b0000, 0);
    cycle(4'b0000, 0, 1'b1);
    cycle(4'b0000, 0);

    // Reset at count 7 with a push pending; the arbiter pointer restarts at 0.
    for (int i = 0; i < 7; i++) begin dat[3] = 8'(8'h50 + i); cycle(4'b1000, 0); end
    dat[3] = 8'hEE; cycle(4'b1000, 0, 1'b1);
    dat[1] = 8'h61; dat[3] = 8'h63;
    cycle(4'b1010, 0);
    cycle(4'b0000, 0);

    // Randomized traffic with held requests and varying pop pressure.
    pend = '0;
    rdp  = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdp = (c / 200 % 3 == 0) ? 20 : (c / 200 % 3 == 1) ? 85 : 50;
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(99) < 40) begin
          pend[i] = 1'b1;
          dat[i]  = 8'($urandom);
        end
      cycle(pend, $urandom_range(99) < rdp, $urandom_range(399) == 0);
      pend = pend & ~acc;
    end
    cycle(4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
